// File: rtl/hi_low_pkg.sv
// Shared types and helpers for the hi/low guessing game sequencer.
// Latency: none (constants, enums and pure functions only).
// Backpressure: not applicable.
package hi_low_pkg;

  // Grade codes consumed by the hiLow seven-segment decoder
  localparam logic [2:0] RES_NONE = 3'd0;
  localparam logic [2:0] RES_LOW  = 3'd1;
  localparam logic [2:0] RES_HIGH = 3'd2;
  localparam logic [2:0] RES_WIN  = 3'd3;
  localparam logic [2:0] RES_LOSE = 3'd4;

  // Largest guess budget (playSwitch == 2'b00)
  localparam int MAX_GUESSES = 4;

  // Game phases
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_t;

  // One LFSR-style step from the seed; an all-zero seed would lock up,
  // so it is replaced by 4'h1 before stepping.
  function automatic logic [3:0] rand_step(input logic [3:0] seed);
    logic [3:0] x;
    x = (seed == 4'h0) ? 4'h1 : seed;
    return {x[2:0], x[3] ^ x[2]};
  endfunction

  // Guess budget for a difficulty setting: 4 - playSwitch
  function automatic logic [2:0] guess_budget(input logic [1:0] play);
    return 3'(MAX_GUESSES) - {1'b0, play};
  endfunction

  // Thermometer code of remaining guesses: (1 << n) - 1
  function automatic logic [3:0] guesses_to_leds(input logic [2:0] n);
    logic [3:0] leds;
    case (n)
      3'd0:    leds = 4'b0000;
      3'd1:    leds = 4'b0001;
      3'd2:    leds = 4'b0011;
      3'd3:    leds = 4'b0111;
      default: leds = 4'b1111;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/button_cond.sv
// Conditions one active-low async pushbutton into a single-cycle press pulse.
// Latency: button low before edge k -> pulse in the cycle after edge k+1+DB_CYCLES.
// Backpressure: none; holding the button gives one pulse, short glitches are dropped.
module button_cond #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic but_n,
  output logic press_pulse
);

  // Counter only has to reach DB_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q,    db_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             pulse_q, pulse_d;

  // Synchronize, count consecutive disagreeing samples, flip the debounced
  // level on the DB_CYCLES-th one, and flag the 1->0 transition.
  always_comb begin
    sync1_d = but_n;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = db_q & ~db_d;
  end

  // Conditioning state; reset means "button released", counter clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/hi_low_game_ctrl.sv
// Hi/low game sequencer: conditions buttons, draws target, grades guesses, counts budget.
// Latency: outputs update one edge after a press pulse (edge k+2+DB_CYCLES from button low).
// Backpressure: none; presses outside PLAY are ignored, new-game overrides a same-cycle guess.
module hi_low_game_ctrl
  import hi_low_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] seedSwitch,
  input  logic [1:0] playSwitch,
  input  logic [3:0] guessSwitch,
  input  logic       randBut,
  input  logic       hiLowBut,
  output logic [3:0] target,
  output logic       reveal,
  output logic [2:0] result,
  output logic [3:0] greenLEDs
);

  logic rand_press;
  logic guess_press;

  button_cond #(.DB_CYCLES(DB_CYCLES)) u_rand_cond (
    .clk         (clk),
    .reset       (reset),
    .but_n       (randBut),
    .press_pulse (rand_press)
  );

  button_cond #(.DB_CYCLES(DB_CYCLES)) u_guess_cond (
    .clk         (clk),
    .reset       (reset),
    .but_n       (hiLowBut),
    .press_pulse (guess_press)
  );

  state_t     state_q,   state_d;
  logic [3:0] target_q,  target_d;
  logic [2:0] guesses_q, guesses_d;
  logic [2:0] result_q,  result_d;
  logic [3:0] leds_q,    leds_d;
  logic       reveal_q,  reveal_d;
  logic [2:0] guesses_dec;

  // Next-state: a new-game press always wins; a guess is graded only in PLAY.
  // Display outputs are derived from the next state so they are all registered.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    guesses_d   = guesses_q;
    result_d    = result_q;
    guesses_dec = guesses_q - 3'd1;

    if (rand_press) begin
      target_d  = rand_step(seedSwitch);
      guesses_d = guess_budget(playSwitch);
      result_d  = RES_NONE;
      state_d   = ST_PLAY;
    end else if (guess_press && (state_q == ST_PLAY)) begin
      if (guessSwitch == target_q) begin
        result_d = RES_WIN;
        state_d  = ST_WIN;
      end else begin
        // PLAY always holds at least one guess, so this never wraps
        guesses_d = guesses_dec;
        if (guesses_dec == 3'd0) begin
          result_d = RES_LOSE;
          state_d  = ST_LOSE;
        end else if (guessSwitch > target_q) begin
          result_d = RES_HIGH;
        end else begin
          result_d = RES_LOW;
        end
      end
    end

    leds_d   = guesses_to_leds(guesses_d);
    reveal_d = (state_d == ST_WIN) || (state_d == ST_LOSE);
  end

  // Game state and registered outputs; reset returns to IDLE with target 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      target_q  <= 4'h0;
      guesses_q <= 3'd0;
      result_q  <= RES_NONE;
      leds_q    <= 4'b0000;
      reveal_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      guesses_q <= guesses_d;
      result_q  <= result_d;
      leds_q    <= leds_d;
      reveal_q  <= reveal_d;
    end
  end

  assign target    = target_q;
  assign reveal    = reveal_q;
  assign result    = result_q;
  assign greenLEDs = leds_q;

endmodule

// File: tb/tb_hi_low_game_ctrl.sv
// Scoreboard bench for hi_low_game_ctrl with a behavioural game model.
// Latency: expected outputs are due at fixed edges after each button action.
// Backpressure: not applicable.
module tb_hi_low_game_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] seedSwitch = 4'h0;
  logic [1:0] playSwitch = 2'b00;
  logic [3:0] guessSwitch = 4'h0;
  logic       randBut = 1'b1;
  logic       hiLowBut = 1'b1;
  logic [3:0] target;
  logic       reveal;
  logic [2:0] result;
  logic [3:0] greenLEDs;

  hi_low_game_ctrl #(.DB_CYCLES(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .seedSwitch  (seedSwitch),
    .playSwitch  (playSwitch),
    .guessSwitch (guessSwitch),
    .randBut     (randBut),
    .hiLowBut    (hiLowBut),
    .target      (target),
    .reveal      (reveal),
    .result      (result),
    .greenLEDs   (greenLEDs)
  );

  always #5 clk = ~clk;

  // Edge counter: after the n-th rising edge, cyc == n
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [3:0] tgt;
    logic [2:0] res;
    logic [3:0] leds;
    logic       rev;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: phase 0=idle 1=playing 2=won 3=lost
  int m_phase = 0;
  int m_target = 0;
  int m_left = 0;
  int m_result = 0;

  function automatic int ref_next(input int seed);
    int x;
    x = (seed == 0) ? 1 : seed;
    return ((x * 2) % 16) + (((x / 8) + (x / 4)) % 2);
  endfunction

  function automatic exp_t cur_exp(input string tag, input int due);
    exp_t e;
    e.due  = due;
    e.tgt  = 4'(m_target);
    e.res  = 3'(m_result);
    e.leds = 4'((1 << m_left) - 1);
    e.rev  = (m_phase >= 2);
    e.tag  = tag;
    return e;
  endfunction

  task automatic model_press(input bit r, input bit g);
    int gs;
    gs = int'(guessSwitch);
    if (r) begin
      m_target = ref_next(int'(seedSwitch));
      m_left   = 4 - int'(playSwitch);
      m_result = 0;
      m_phase  = 1;
    end else if (g && m_phase == 1) begin
      if (gs == m_target) begin
        m_result = 3;
        m_phase  = 2;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_result = 4;
          m_phase  = 3;
        end else begin
          m_result = (gs > m_target) ? 2 : 1;
        end
      end
    end
  endtask

  // Hold the selected buttons low for 'hold' samples, then release and settle.
  task automatic do_press(input bit r, input bit g, input int hold, input string tag);
    int c;
    @(negedge clk);
    c = cyc;
    exp_q.push_back(cur_exp({tag, "_pre"}, c + 2 + DB));
    if (hold >= DB) model_press(r, g);
    exp_q.push_back(cur_exp(tag, c + 3 + DB));
    if (r) randBut = 1'b0;
    if (g) hiLowBut = 1'b0;
    repeat (hold) @(negedge clk);
    randBut  = 1'b1;
    hiLowBut = 1'b1;
    repeat (DB + 6) @(negedge clk);
  endtask

  task automatic check_now(input string tag);
    @(negedge clk);
    exp_q.push_back(cur_exp(tag, cyc + 1));
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    m_phase = 0; m_target = 0; m_left = 0; m_result = 0;
    exp_q.push_back(cur_exp(tag, cyc + 1));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Monitor: compare every expectation at its due cycle; overdue ones fail.
  exp_t mon_e;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.due < cyc) begin
        checks++; failures++;
        $display("FAIL %s overdue: now=%0d due=%0d", mon_e.tag, cyc, mon_e.due);
      end else begin
        checks++;
        if (target !== mon_e.tgt) begin
          failures++;
          $display("FAIL %s target: got=%h exp=%h", mon_e.tag, target, mon_e.tgt);
        end
        checks++;
        if (result !== mon_e.res) begin
          failures++;
          $display("FAIL %s result: got=%0d exp=%0d", mon_e.tag, result, mon_e.res);
        end
        checks++;
        if (greenLEDs !== mon_e.leds) begin
          failures++;
          $display("FAIL %s greenLEDs: got=%b exp=%b", mon_e.tag, greenLEDs, mon_e.leds);
        end
        checks++;
        if (reveal !== mon_e.rev) begin
          failures++;
          $display("FAIL %s reveal: got=%b exp=%b", mon_e.tag, reveal, mon_e.rev);
        end
      end
    end
  end

  initial begin
    int act;
    int hold;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_now("reset_state");

    // Guess in IDLE is ignored
    guessSwitch = 4'h5;
    do_press(1'b0, 1'b1, DB + 3, "idle_guess");

    // Easy game: seed 1111 -> target 14, four guesses
    playSwitch = 2'b00; seedSwitch = 4'hF;
    do_press(1'b1, 1'b0, DB + 3, "new_seedF");
    guessSwitch = 4'h2;
    do_press(1'b0, 1'b1, DB + 3, "guess_low");

    // Seed 1110 -> target 12; HIGH then WIN, then ignored guess
    seedSwitch = 4'hE;
    do_press(1'b1, 1'b0, DB + 3, "new_seedE");
    guessSwitch = 4'hF;
    do_press(1'b0, 1'b1, DB + 3, "guess_high");
    guessSwitch = 4'hC;
    do_press(1'b0, 1'b1, DB + 3, "guess_win");
    guessSwitch = 4'h1;
    do_press(1'b0, 1'b1, DB + 3, "after_win");

    // Single-guess game: seed 1010 -> target 5, miss -> LOSE
    playSwitch = 2'b11; seedSwitch = 4'hA;
    do_press(1'b1, 1'b0, DB + 3, "new_hard");
    guessSwitch = 4'h0;
    do_press(1'b0, 1'b1, DB + 3, "guess_lose");

    // Both buttons together mid-game; seed 0 -> target 2
    playSwitch = 2'b01; seedSwitch = 4'h3;
    do_press(1'b1, 1'b0, DB + 3, "new_mid");
    guessSwitch = 4'h0; seedSwitch = 4'h0;
    do_press(1'b1, 1'b1, DB + 3, "both_press");

    // Glitch shorter than DB is rejected
    do_press(1'b0, 1'b1, DB - 1, "glitch");

    // Long hold grades exactly once
    do_press(1'b0, 1'b1, 100, "long_hold");
    check_now("long_hold_after");

    // Reset mid-game
    reset = 1'b0;
    do_reset("mid_reset");
    check_now("post_reset");

    // Randomized play
    for (int i = 0; i < 40; i++) begin
      act  = int'($urandom_range(0, 9));
      hold = int'($urandom_range(DB, DB + 10));
      if (act <= 1) begin
        seedSwitch = 4'($urandom_range(0, 15));
        playSwitch = 2'($urandom_range(0, 3));
        do_press(1'b1, 1'b0, hold, "rnd_new");
      end else if (act <= 7) begin
        guessSwitch = ($urandom_range(0, 3) == 0) ? 4'(m_target) : 4'($urandom_range(0, 15));
        do_press(1'b0, 1'b1, hold, "rnd_guess");
      end else if (act == 8) begin
        seedSwitch = 4'($urandom_range(0, 15));
        guessSwitch = 4'($urandom_range(0, 15));
        do_press(1'b1, 1'b1, hold, "rnd_both");
      end else begin
        guessSwitch = 4'($urandom_range(0, 15));
        do_press(1'b0, 1'b1, int'($urandom_range(1, DB - 1)), "rnd_glitch");
      end
    end

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
